// File: rtl/mmio_responder_pkg.sv
// Shared types and constants for the MMIO responder slice.
package mmio_responder_pkg;

  typedef enum logic [1:0] {MMIO_IDLE, MMIO_WAIT, MMIO_RESP} mmio_state_t;

  // Register offsets inside the 256-byte window (8-byte aligned)
  localparam logic [7:0] MMIO_TCOUNT  = 8'h00;
  localparam logic [7:0] MMIO_TCMP    = 8'h08;
  localparam logic [7:0] MMIO_TCTRL   = 8'h10;
  localparam logic [7:0] MMIO_UTX     = 8'h18;
  localparam logic [7:0] MMIO_USTAT   = 8'h20;
  localparam logic [7:0] MMIO_SCRATCH = 8'h28;

  // Access size encoding, shared with data_mem
  localparam logic [2:0] MEM_NONE  = 3'd0;
  localparam logic [2:0] MEM_BYTE  = 3'd1;
  localparam logic [2:0] MEM_HALF  = 3'd2;
  localparam logic [2:0] MEM_WORD  = 3'd3;
  localparam logic [2:0] MEM_DWORD = 3'd4;

  // Byte-enable pattern for an access of the given size starting at lane 0
  function automatic logic [7:0] size_byte_mask(input logic [2:0] size);
    case (size)
      MEM_BYTE:  return 8'h01;
      MEM_HALF:  return 8'h03;
      MEM_WORD:  return 8'h0F;
      MEM_DWORD: return 8'hFF;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Data-side MMIO bus between the core (master) and the responder (slave).
interface mmio_responder_if;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [2:0]  mem_load_type;
  logic [2:0]  mem_store_type;
  logic        d_valid;
  logic        d_ready;
  logic [63:0] d_rdata;

  modport master (
    output addr, wdata, mem_load_type, mem_store_type,
    input  d_valid, d_ready, d_rdata
  );

  modport slave (
    input  addr, wdata, mem_load_type, mem_store_type,
    output d_valid, d_ready, d_rdata
  );
endinterface

// File: rtl/mmio_responder_tx_fifo.sv
// Small power-of-two FIFO feeding the UART transmitter.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_responder.sv
// MMIO target: timer, scratch register and UART TX FIFO behind a fixed-latency handshake.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0000_A000,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  output logic [7:0]        interrupt_sources,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // 64-bit bit mask for the bytes touched; lanes wrap inside the register
  function automatic logic [63:0] lane_mask(input logic [2:0] size, input logic [2:0] lane);
    logic [15:0] sh;
    logic [7:0]  bm;
    logic [63:0] m;
    sh = {8'h00, size_byte_mask(size)} << lane;
    bm = sh[7:0] | sh[15:8];
    for (int unsigned i = 0; i < 8; i++) m[8*i +: 8] = {8{bm[i]}};
    return m;
  endfunction

  // Rotate low-aligned store data up to its byte lane
  function automatic logic [63:0] lane_place(input logic [63:0] data, input logic [2:0] lane);
    logic [127:0] dd;
    dd = {data, data} << {lane, 3'b000};
    return dd[127:64];
  endfunction

  // Shift the register down to the lane, keep only the access size
  function automatic logic [63:0] lane_extract(input logic [63:0] word, input logic [2:0] lane,
                                               input logic [2:0] size);
    return (word >> {lane, 3'b000}) & lane_mask(size, 3'd0);
  endfunction

  mmio_state_t state;
  logic [3:0]  cnt;
  logic [7:0]  req_off;
  logic [63:0] req_wdata;
  logic [2:0]  req_load;
  logic [2:0]  req_store;
  logic        d_ready_q;

  logic [63:0] tcount, tcmp, scratch;
  logic        en, pend, tie, uie, ovf;

  logic          in_window;
  logic          commit, wr;
  logic [7:0]    reg_off;
  logic [63:0]   wmask, wbits, rd_word;
  logic          push, pop, full, empty;
  logic [CW-1:0] fifo_count;
  logic [2:0]    count3;

  assign in_window   = (bus.addr >= BASE_ADDR) && (bus.addr <= BASE_ADDR + 64'hFF);
  assign bus.d_valid = in_window && (bus.mem_load_type != MEM_NONE || bus.mem_store_type != MEM_NONE);
  assign bus.d_ready = d_ready_q;

  assign commit  = (state == MMIO_RESP);
  assign wr      = commit && (req_store != MEM_NONE);
  assign reg_off = {req_off[7:3], 3'b000};
  assign wmask   = lane_mask(req_store, req_off[2:0]);
  assign wbits   = lane_place(req_wdata, req_off[2:0]) & wmask;

  // Request handshake: latch on d_valid, count wait states, pulse d_ready once
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MMIO_IDLE;
      cnt       <= '0;
      req_off   <= '0;
      req_wdata <= '0;
      req_load  <= MEM_NONE;
      req_store <= MEM_NONE;
      d_ready_q <= 1'b0;
    end else begin
      d_ready_q <= 1'b0;
      case (state)
        MMIO_IDLE: if (bus.d_valid) begin
          req_off   <= bus.addr[7:0];
          req_wdata <= bus.wdata;
          req_load  <= bus.mem_load_type;
          req_store <= bus.mem_store_type;
          cnt       <= 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state     <= MMIO_RESP;
            d_ready_q <= 1'b1;
          end else begin
            state <= MMIO_WAIT;
          end
        end
        MMIO_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= MMIO_RESP;
            d_ready_q <= 1'b1;
          end
        end
        MMIO_RESP: state <= MMIO_IDLE;
        default:   state <= MMIO_IDLE;
      endcase
    end
  end

  assign push = wr && (reg_off == MMIO_UTX);
  assign pop  = uart_tx_valid && uart_tx_ready;

  // Timer, control bits, scratch and sticky overflow; stores commit in the RESP cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      tcount  <= '0;
      tcmp    <= '0;
      scratch <= '0;
      en      <= 1'b0;
      pend    <= 1'b0;
      tie     <= 1'b0;
      uie     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (en) tcount <= tcount + 64'd1;
      if (wr && reg_off == MMIO_TCMP)    tcmp    <= (tcmp & ~wmask) | wbits;
      if (wr && reg_off == MMIO_SCRATCH) scratch <= (scratch & ~wmask) | wbits;
      if (wr && reg_off == MMIO_TCTRL) begin
        if (wmask[0]) en  <= wbits[0];
        if (wmask[2]) tie <= wbits[2];
        if (wmask[3]) uie <= wbits[3];
      end
      // A compare match outranks a simultaneous W1C
      if (en && tcount == tcmp)                          pend <= 1'b1;
      else if (wr && reg_off == MMIO_TCTRL && wbits[1])  pend <= 1'b0;
      if (push && full && !pop)                          ovf  <= 1'b1;
      else if (wr && reg_off == MMIO_USTAT && wbits[5])  ovf  <= 1'b0;
    end
  end

  assign count3 = 3'(fifo_count);

  // Read-side register view
  always_comb begin
    rd_word = '0;
    case (reg_off)
      MMIO_TCOUNT:  rd_word = tcount;
      MMIO_TCMP:    rd_word = tcmp;
      MMIO_TCTRL:   rd_word = {60'd0, uie, tie, pend, en};
      MMIO_USTAT:   rd_word = {58'd0, ovf, count3, empty, full};
      MMIO_SCRATCH: rd_word = scratch;
      default:      rd_word = '0;
    endcase
  end

  assign bus.d_rdata = (d_ready_q && req_load != MEM_NONE)
                       ? lane_extract(rd_word, req_off[2:0], req_load) : '0;

  assign uart_tx_valid     = !empty;
  assign interrupt_sources = {6'd0, empty & uie, pend & tie};

  tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req_wdata[7:0]),
    .dout  (uart_tx_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: one instance with 1 wait state, one with 3.
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, rst3;
  logic       uart_ready, uart_ready3;
  logic [7:0] irq, irq3, utx_data, utx_data3;
  logic       utx_valid, utx_valid3;

  mmio_responder_if bus0();
  mmio_responder_if bus1();

  mmio_responder #(.BASE_ADDR(64'h0000_0000_0000_A000), .WAIT_STATES(1), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus0), .interrupt_sources(irq),
    .uart_tx_data(utx_data), .uart_tx_valid(utx_valid), .uart_tx_ready(uart_ready));

  mmio_responder #(.BASE_ADDR(64'h0000_0000_0000_A000), .WAIT_STATES(3), .FIFO_DEPTH(DEPTH)) dut3 (
    .clock(clock), .reset(rst3), .bus(bus1), .interrupt_sources(irq3),
    .uart_tx_data(utx_data3), .uart_tx_valid(utx_valid3), .uart_tx_ready(uart_ready3));

  int n_cmp = 0;
  int n_bad = 0;
  int rdy0 = 0;
  int rdy1 = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  uart_q[$];
  bit          m_ovf = 0;

  // Count every d_ready pulse on both instances
  always @(negedge clock) begin
    if (bus0.d_ready === 1'b1) rdy0++;
    if (bus1.d_ready === 1'b1) rdy1++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus(input int sel);
    if (sel == 0) begin
      bus0.mem_load_type = MEM_NONE; bus0.mem_store_type = MEM_NONE;
    end else begin
      bus1.mem_load_type = MEM_NONE; bus1.mem_store_type = MEM_NONE;
    end
  endtask

  // Drive one request, push its expected read data, then pop and compare at d_ready
  task automatic access(input int sel, input bit st, input logic [2:0] size,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp, input string tag);
    int lat;
    bit rdy;
    logic [63:0] got;
    @(negedge clock);
    if (sel == 0) begin
      bus0.addr = a; bus0.wdata = wd;
      bus0.mem_load_type  = st ? MEM_NONE : size;
      bus0.mem_store_type = st ? size : MEM_NONE;
    end else begin
      bus1.addr = a; bus1.wdata = wd;
      bus1.mem_load_type  = st ? MEM_NONE : size;
      bus1.mem_store_type = st ? size : MEM_NONE;
    end
    exp_q.push_back(exp);
    #1;
    check({tag, "/d_valid"}, (sel == 0) ? bus0.d_valid : bus1.d_valid, 1);
    lat = 0;
    rdy = 0;
    got = '0;
    while (!rdy && lat < 20) begin
      @(negedge clock);
      lat++;
      rdy = (sel == 0) ? bus0.d_ready : bus1.d_ready;
      got = (sel == 0) ? bus0.d_rdata : bus1.d_rdata;
    end
    check({tag, "/latency"}, lat, (sel == 0) ? 2 : 4);
    check({tag, "/rdata"}, got, exp_q.pop_front());
    idle_bus(sel);
  endtask

  task automatic utx_store(input logic [7:0] b);
    access(0, 1, MEM_BYTE, 64'hA018, {56'd0, b}, 64'd0, "utx_store");
    if (uart_q.size() < DEPTH) uart_q.push_back(b);
    else m_ovf = 1;
  endtask

  function automatic logic [63:0] ustat_exp();
    int n;
    n = uart_q.size();
    return {58'd0, m_ovf, 3'(n), (n == 0), (n == DEPTH)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drained;
    int c;
    logic [7:0] e;
    reset = 1; rst3 = 1; uart_ready = 0; uart_ready3 = 0;
    bus0.addr = '0; bus0.wdata = '0; bus1.addr = '0; bus1.wdata = '0;
    idle_bus(0); idle_bus(1);
    repeat (3) @(negedge clock);
    reset = 0; rst3 = 0;
    @(negedge clock);
    check("rst/d_ready", bus0.d_ready, 0);
    check("rst/d_rdata", bus0.d_rdata, 0);
    check("rst/irq", irq, 0);
    check("rst/uart_valid", utx_valid, 0);
    access(0, 0, MEM_DWORD, 64'hA028, 0, 64'd0, "rst_scratch");

    // Scratch round trip with byte-lane masking
    access(0, 1, MEM_DWORD, 64'hA028, 64'hDEAD_BEEF_0123_4567, 0, "scr_st");
    access(0, 0, MEM_BYTE,  64'hA02A, 0, 64'h23, "scr_ld_b");
    access(0, 0, MEM_HALF,  64'hA02C, 0, 64'hBEEF, "scr_ld_h");
    access(0, 1, MEM_BYTE,  64'hA02B, 64'h99, 0, "scr_st_b");
    access(0, 0, MEM_DWORD, 64'hA028, 0, 64'hDEAD_BEEF_9923_4567, "scr_ld_d");
    access(0, 0, MEM_WORD,  64'hA028, 0, 64'h9923_4567, "scr_ld_w");

    // Timer compare, interrupt, W1C
    access(0, 1, MEM_DWORD, 64'hA008, 64'd5, 0, "tcmp_st");
    access(0, 1, MEM_DWORD, 64'hA010, 64'd5, 0, "tctrl_en");
    repeat (12) @(negedge clock);
    check("timer/irq_set", irq, 8'h01);
    access(0, 0, MEM_DWORD, 64'hA010, 0, 64'd7, "tctrl_pend");
    access(0, 1, MEM_DWORD, 64'hA010, 64'd7, 0, "tctrl_w1c");
    @(negedge clock);
    check("timer/irq_clr", irq, 8'h00);
    access(0, 0, MEM_DWORD, 64'hA010, 0, 64'd5, "tctrl_after");
    access(0, 1, MEM_DWORD, 64'hA010, 64'd8, 0, "tctrl_uie");
    @(negedge clock);
    check("uie/irq", irq, 8'h02);
    access(0, 1, MEM_DWORD, 64'hA010, 64'd0, 0, "tctrl_off");

    // FIFO fill past capacity with the consumer stalled
    for (int i = 0; i < 5; i++) utx_store(8'h41 + 8'(i));
    check("fifo/head", utx_data, 8'h41);
    check("fifo/valid", utx_valid, 1);
    access(0, 0, MEM_DWORD, 64'hA020, 0, ustat_exp(), "ustat_full");
    @(negedge clock);
    uart_ready = 1;
    drained = 0;
    for (int i = 0; i < 12; i++) begin
      if (!utx_valid) break;
      e = (uart_q.size() > 0) ? uart_q.pop_front() : 8'hxx;
      check("fifo/drain", utx_data, e);
      drained++;
      @(negedge clock);
    end
    uart_ready = 0;
    check("fifo/drained", drained, 4);
    access(0, 0, MEM_DWORD, 64'hA020, 0, ustat_exp(), "ustat_empty");
    access(0, 1, MEM_BYTE, 64'hA020, 64'h20, 0, "ovf_w1c");
    m_ovf = 0;
    access(0, 0, MEM_DWORD, 64'hA020, 0, ustat_exp(), "ustat_clr");

    // Unmapped offset: reads zero, store touches nothing
    access(0, 1, MEM_DWORD, 64'hA0F8, 64'hFFFF_FFFF_FFFF_FFFF, 0, "unm_st");
    access(0, 0, MEM_DWORD, 64'hA0F8, 0, 64'd0, "unm_ld");
    access(0, 0, MEM_DWORD, 64'hA028, 0, 64'hDEAD_BEEF_9923_4567, "unm_scr");
    access(0, 0, MEM_DWORD, 64'hA008, 0, 64'd5, "unm_tcmp");
    access(0, 0, MEM_DWORD, 64'hA010, 0, 64'd0, "unm_tctrl");

    // Outside the window and no-op types
    @(negedge clock);
    bus0.addr = 64'h1000; bus0.mem_load_type = MEM_DWORD;
    c = rdy0;
    #1 check("oow/d_valid", bus0.d_valid, 0);
    repeat (5) @(negedge clock);
    check("oow/no_resp", rdy0, c);
    bus0.addr = 64'hA100;
    #1 check("above/d_valid", bus0.d_valid, 0);
    idle_bus(0);
    bus0.addr = 64'hA028;
    #1 check("notype/d_valid", bus0.d_valid, 0);

    // Three wait states, then reset in the middle of a UTX store
    access(1, 1, MEM_DWORD, 64'hA028, 64'h1234, 0, "ws3_st");
    access(1, 0, MEM_HALF, 64'hA028, 0, 64'h1234, "ws3_ld");
    @(negedge clock);
    bus1.addr = 64'hA018; bus1.wdata = 64'h55; bus1.mem_store_type = MEM_BYTE;
    c = rdy1;
    repeat (2) @(negedge clock);
    rst3 = 1;
    @(negedge clock);
    check("abort/d_ready", bus1.d_ready, 0);
    idle_bus(1);
    rst3 = 0;
    repeat (6) @(negedge clock);
    check("abort/no_resp", rdy1, c);
    check("abort/fifo_empty", utx_valid3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
